// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned DATA_W     = 32;
    localparam logic [7:0]  RESET_PC   = 8'h00;
    localparam logic [31:0] NULL_INSTR = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_register.sv
// Program counter register: synchronous reset, load (redirect) over increment by 4.
module pc_register #(
    parameter int unsigned          ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IF/ID register and RUN/HALT control.
// Halts on the ROM null word; only a redirect or reset restarts fetching.
module fetch_stage #(
    parameter int unsigned       ADDR_W   = fetch_pkg::ADDR_W,
    parameter int unsigned       DATA_W   = fetch_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rd,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    output logic              halted
);

    import fetch_pkg::*;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] redirect_tgt;
    logic              instr_null;
    logic              fetch_ok;

    fetch_state_t      state_q,       state_d;
    logic              if_valid_q,    if_valid_d;
    logic [DATA_W-1:0] if_instr_q,    if_instr_d;
    logic [ADDR_W-1:0] if_pc_q,       if_pc_d;
    logic [ADDR_W-1:0] if_pc_plus4_q, if_pc_plus4_d;
    logic              halted_q,      halted_d;

    // Targets are word aligned; the low two bits of the request are dropped.
    assign redirect_tgt = redirect_pc & ~ADDR_W'(3);
    assign instr_null   = (imem_rd == DATA_W'(NULL_INSTR));
    assign fetch_ok     = !redirect && !stall && (state_q == RUN) && !instr_null;

    pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst     (rst),
        .load    (redirect),
        .load_pc (redirect_tgt),
        .inc     (fetch_ok),
        .pc      (pc)
    );

    always_comb begin
        state_d       = state_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        halted_d      = halted_q;
        if (redirect) begin
            if_valid_d = 1'b0;
            state_d    = RUN;
            halted_d   = 1'b0;
        end else if (!stall && state_q == RUN) begin
            if (instr_null) begin
                if_valid_d = 1'b0;
                state_d    = HALT;
                halted_d   = 1'b1;
            end else begin
                if_valid_d    = 1'b1;
                if_instr_d    = imem_rd;
                if_pc_d       = pc;
                if_pc_plus4_d = pc + ADDR_W'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            if_pc_plus4_q <= '0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            halted_q      <= halted_d;
        end
    end

    assign imem_addr   = pc;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rd;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [7:0]  if_pc;
    logic [7:0]  if_pc_plus4;
    logic        halted;

    logic [31:0] rom [0:63];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [57:0] obs;
    logic [57:0] exp;

    always #5 clk = ~clk;

    assign imem_rd = rom[imem_addr[7:2]];

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .halted      (halted)
    );

    // Advance one edge, settle, and log the transaction.
    task automatic step();
        @(posedge clk);
        #1;
        obs = {halted, if_valid, imem_addr, if_pc, if_pc_plus4, if_instr};
        $display("t=%0t rst=%b stall=%b redir=%b rpc=%h | addr=%h v=%b pc=%h pc4=%h instr=%h halt=%b",
                 $time, rst, stall, redirect, redirect_pc, imem_addr, if_valid, if_pc, if_pc_plus4,
                 if_instr, halted);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        rom[0] = 32'h0FF00083;
        rom[1] = 32'h0E100FA3;
        rom[2] = 32'hFE000CE3;
        rst = 1'b1;
        step();
        step();
        exp = {1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 32'h0};
        total_cnt++;
        if (obs !== exp) $display("FAIL reset: got %h want %h", obs, exp);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] words [3];
        words[0] = 32'h0FF00083;
        words[1] = 32'h0E100FA3;
        words[2] = 32'hFE000CE3;
        for (int i = 0; i < 3; i++) begin
            step();
            exp = {1'b0, 1'b1, 8'(4 * i + 4), 8'(4 * i), 8'(4 * i + 4), words[i]};
            total_cnt++;
            if (obs !== exp) $display("FAIL seq_fetch_%0d: got %h want %h", i, obs, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_null_halt();
        for (int i = 0; i < 5; i++) begin
            step();
            exp = {1'b1, 1'b0, 8'h0C, 8'h08, 8'h0C, 32'hFE000CE3};
            total_cnt++;
            if (obs !== exp) $display("FAIL halt_hold_%0d: got %h want %h", i, obs, exp);
            else pass_cnt++;
        end
        redirect = 1'b1;
        redirect_pc = 8'h00;
        step();
        exp = {1'b0, 1'b0, 8'h00, 8'h08, 8'h0C, 32'hFE000CE3};
        total_cnt++;
        if (obs !== exp) $display("FAIL halt_redirect_bubble: got %h want %h", obs, exp);
        else pass_cnt++;
        redirect = 1'b0;
        step();
        exp = {1'b0, 1'b1, 8'h04, 8'h00, 8'h04, 32'h0FF00083};
        total_cnt++;
        if (obs !== exp) $display("FAIL halt_redirect_target: got %h want %h", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            exp = {1'b0, 1'b1, 8'h04, 8'h00, 8'h04, 32'h0FF00083};
            total_cnt++;
            if (obs !== exp) $display("FAIL stall_hold_%0d: got %h want %h", i, obs, exp);
            else pass_cnt++;
        end
        redirect = 1'b1;
        redirect_pc = 8'h0B;
        step();
        exp = {1'b0, 1'b0, 8'h08, 8'h00, 8'h04, 32'h0FF00083};
        total_cnt++;
        if (obs !== exp) $display("FAIL stall_with_redirect: got %h want %h", obs, exp);
        else pass_cnt++;
        stall = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic test_wrap();
        rom[63] = 32'h00100093;
        redirect = 1'b1;
        redirect_pc = 8'hFC;
        step();
        exp = {1'b0, 1'b0, 8'hFC, 8'h00, 8'h04, 32'h0FF00083};
        total_cnt++;
        if (obs !== exp) $display("FAIL wrap_redirect: got %h want %h", obs, exp);
        else pass_cnt++;
        redirect = 1'b0;
        step();
        exp = {1'b0, 1'b1, 8'h00, 8'hFC, 8'h00, 32'h00100093};
        total_cnt++;
        if (obs !== exp) $display("FAIL wrap_fetch: got %h want %h", obs, exp);
        else pass_cnt++;
        step();
        exp = {1'b0, 1'b1, 8'h04, 8'h00, 8'h04, 32'h0FF00083};
        total_cnt++;
        if (obs !== exp) $display("FAIL wrap_next: got %h want %h", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        redirect = 1'b1;
        redirect_pc = 8'h0C;
        step();
        redirect = 1'b0;
        step();
        exp = {1'b1, 1'b0, 8'h0C, 8'h00, 8'h04, 32'h0FF00083};
        total_cnt++;
        if (obs !== exp) $display("FAIL mid_enter_halt: got %h want %h", obs, exp);
        else pass_cnt++;
        rst = 1'b1;
        step();
        exp = {1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 32'h0};
        total_cnt++;
        if (obs !== exp) $display("FAIL reset_in_halt: got %h want %h", obs, exp);
        else pass_cnt++;
        rst = 1'b0;
        step();
        stall = 1'b1;
        step();
        exp = {1'b0, 1'b1, 8'h04, 8'h00, 8'h04, 32'h0FF00083};
        total_cnt++;
        if (obs !== exp) $display("FAIL mid_stall_hold: got %h want %h", obs, exp);
        else pass_cnt++;
        rst = 1'b1;
        redirect = 1'b1;
        redirect_pc = 8'h40;
        step();
        exp = {1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 32'h0};
        total_cnt++;
        if (obs !== exp) $display("FAIL reset_in_stall: got %h want %h", obs, exp);
        else pass_cnt++;
        rst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        step();
        exp = {1'b0, 1'b1, 8'h04, 8'h00, 8'h04, 32'h0FF00083};
        total_cnt++;
        if (obs !== exp) $display("FAIL run_after_reset: got %h want %h", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [7:0]  m_pc;
        logic        m_valid;
        logic [31:0] m_instr;
        logic [7:0]  m_ifpc;
        logic [7:0]  m_plus4;
        logic        m_halt;
        logic [31:0] w;
        for (int i = 0; i < 64; i++) rom[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        step();
        m_pc = 8'h00; m_valid = 1'b0; m_instr = 32'h0;
        m_ifpc = 8'h00; m_plus4 = 8'h00; m_halt = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 9) == 0);
            redirect_pc = 8'($urandom);
            if (rst) begin
                m_pc = 8'h00; m_valid = 1'b0; m_instr = 32'h0;
                m_ifpc = 8'h00; m_plus4 = 8'h00; m_halt = 1'b0;
            end else if (redirect) begin
                m_pc = {redirect_pc[7:2], 2'b00};
                m_valid = 1'b0;
                m_halt = 1'b0;
            end else if (!stall && !m_halt) begin
                w = rom[m_pc / 4];
                if (w != 32'h0) begin
                    m_valid = 1'b1;
                    m_instr = w;
                    m_ifpc = m_pc;
                    m_plus4 = m_pc + 8'd4;
                    m_pc = m_pc + 8'd4;
                end else begin
                    m_valid = 1'b0;
                    m_halt = 1'b1;
                end
            end
            step();
            exp = {m_halt, m_valid, m_pc, m_ifpc, m_plus4, m_instr};
            total_cnt++;
            if (obs !== exp) $display("FAIL random_cycle_%0d: got %h want %h", c, obs, exp);
            else pass_cnt++;
        end
        rst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_null_halt();
        test_stall_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
